// File: rtl/arc4_pkg.sv
// Shared types and helpers for the ARC4 encryptor.
// Holds the top-level state enum, the KSA/PRGA sub-step enum and key byte selection.
package arc4_pkg;

    localparam int S_SIZE            = 256;
    localparam int KEY_BYTES_DEFAULT = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_KSA,
        ST_LEN,
        ST_PRGA,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        SS_RD_I,
        SS_RD_J,
        SS_WR_I,
        SS_WR_J,
        SS_RD_K,
        SS_WR_CT
    } step_t;

    // Key byte 0 is the most significant byte of the key word.
    function automatic logic [7:0] keybyte(
        input logic [8*KEY_BYTES_DEFAULT-1:0] key,
        input int unsigned                    idx,
        input int unsigned                    nbytes
    );
        logic [8*KEY_BYTES_DEFAULT-1:0] sh;
        sh = key >> (8 * (nbytes - 1 - idx));
        return sh[7:0];
    endfunction

endpackage

// File: rtl/arc4_enc_s_mem.sv
// 256x8 single-port synchronous RAM holding the ARC4 state array S.
// Read data appears one cycle after the address is presented.
module s_mem
    import arc4_pkg::*;
(
    input  logic       clk,
    input  logic [7:0] addr,
    input  logic [7:0] wrdata,
    input  logic       wren,
    output logic [7:0] rddata
);

    logic [7:0] mem [S_SIZE];

    // Registered read port with optional write on the same address
    always_ff @(posedge clk) begin
        if (wren) begin
            mem[addr] <= wrdata;
        end
        rddata <= mem[addr];
    end

endmodule

// File: rtl/arc4_enc.sv
// ARC4 encryptor: reads a length-prefixed plaintext, runs KSA and PRGA over an
// internal S RAM and writes the length-prefixed ciphertext.
// Optional feature macro: ARC4_ENC_CYCLE_COUNT_EN adds a 32-bit busy-cycle counter output.
module arc4_enc
    import arc4_pkg::*;
#(
    parameter int KEY_BYTES = KEY_BYTES_DEFAULT,
    parameter int ADDR_W    = 8
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [ADDR_W-1:0]      pt_addr,
    input  logic [7:0]             pt_rddata,
    output logic [ADDR_W-1:0]      ct_addr,
    output logic [7:0]             ct_wrdata,
    output logic                   ct_wren
`ifdef ARC4_ENC_CYCLE_COUNT_EN
    ,
    output logic [31:0]            cycles
`endif
);

    state_t                 state, state_n;
    step_t                  step, step_n;
    logic [7:0]             i, i_n, j, j_n;
    logic [7:0]             si, si_n, sj, sj_n;
    logic [7:0]             pt_byte, pt_byte_n;
    logic [7:0]             jsum;
    logic [ADDR_W-1:0]      k, k_n, len, len_n;
    logic [8*KEY_BYTES-1:0] key_r, key_r_n;
    logic [1:0]             kidx, kidx_n;
    logic [7:0]             s_addr, s_wrdata, s_rddata;
    logic                   s_wren;
    logic                   accept;

    s_mem u_s_mem (
        .clk    (clk),
        .addr   (s_addr),
        .wrdata (s_wrdata),
        .wren   (s_wren),
        .rddata (s_rddata)
    );

    // State and datapath registers, all cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            step    <= SS_RD_I;
            i       <= '0;
            j       <= '0;
            si      <= '0;
            sj      <= '0;
            pt_byte <= '0;
            k       <= '0;
            len     <= '0;
            key_r   <= '0;
            kidx    <= '0;
        end else begin
            state   <= state_n;
            step    <= step_n;
            i       <= i_n;
            j       <= j_n;
            si      <= si_n;
            sj      <= sj_n;
            pt_byte <= pt_byte_n;
            k       <= k_n;
            len     <= len_n;
            key_r   <= key_r_n;
            kidx    <= kidx_n;
        end
    end

    // Next-state, S RAM sequencing and RAM port outputs
    always_comb begin
        state_n   = state;
        step_n    = step;
        i_n       = i;
        j_n       = j;
        si_n      = si;
        sj_n      = sj;
        pt_byte_n = pt_byte;
        k_n       = k;
        len_n     = len;
        key_r_n   = key_r;
        kidx_n    = kidx;
        jsum      = '0;
        s_addr    = '0;
        s_wrdata  = '0;
        s_wren    = 1'b0;
        pt_addr   = '0;
        ct_addr   = '0;
        ct_wrdata = '0;
        ct_wren   = 1'b0;
        rdy       = (state == ST_IDLE) || (state == ST_DONE);
        accept    = rdy && en;

        case (state)
            ST_IDLE, ST_DONE: begin
                state_n = ST_IDLE;
                if (en) begin
                    state_n = ST_INIT;
                    step_n  = SS_RD_I;
                    key_r_n = key;
                    i_n     = '0;
                    j_n     = '0;
                    k_n     = '0;
                    kidx_n  = '0;
                end
            end
            ST_INIT: begin
                s_addr   = i;
                s_wrdata = i;
                s_wren   = 1'b1;
                i_n      = i + 8'd1;
                if (i == 8'hFF) begin
                    state_n = ST_KSA;
                    step_n  = SS_RD_I;
                end
            end
            ST_KSA: begin
                case (step)
                    SS_RD_I: begin
                        s_addr = i;
                        step_n = SS_RD_J;
                    end
                    SS_RD_J: begin
                        jsum   = j + s_rddata + keybyte(key_r, int'(kidx), KEY_BYTES);
                        s_addr = jsum;
                        j_n    = jsum;
                        si_n   = s_rddata;
                        step_n = SS_WR_I;
                    end
                    SS_WR_I: begin
                        s_addr   = i;
                        s_wrdata = s_rddata;
                        s_wren   = 1'b1;
                        step_n   = SS_WR_J;
                    end
                    SS_WR_J: begin
                        s_addr   = j;
                        s_wrdata = si;
                        s_wren   = 1'b1;
                        i_n      = i + 8'd1;
                        kidx_n   = (kidx == 2'(KEY_BYTES - 1)) ? 2'd0 : kidx + 2'd1;
                        step_n   = SS_RD_I;
                        if (i == 8'hFF) begin
                            state_n = ST_LEN;
                        end
                    end
                    default: step_n = SS_RD_I;
                endcase
            end
            ST_LEN: begin
                if (step == SS_RD_I) begin
                    pt_addr = '0;
                    step_n  = SS_RD_J;
                end else begin
                    ct_addr   = '0;
                    ct_wrdata = pt_rddata;
                    ct_wren   = 1'b1;
                    len_n     = ADDR_W'(pt_rddata);
                    i_n       = '0;
                    j_n       = '0;
                    k_n       = ADDR_W'(1);
                    step_n    = SS_RD_I;
                    state_n   = (pt_rddata == 8'd0) ? ST_DONE : ST_PRGA;
                end
            end
            ST_PRGA: begin
                case (step)
                    SS_RD_I: begin
                        i_n     = i + 8'd1;
                        s_addr  = i + 8'd1;
                        pt_addr = k;
                        step_n  = SS_RD_J;
                    end
                    SS_RD_J: begin
                        pt_byte_n = pt_rddata;
                        si_n      = s_rddata;
                        jsum      = j + s_rddata;
                        s_addr    = jsum;
                        j_n       = jsum;
                        step_n    = SS_WR_I;
                    end
                    SS_WR_I: begin
                        s_addr   = i;
                        s_wrdata = s_rddata;
                        s_wren   = 1'b1;
                        sj_n     = s_rddata;
                        step_n   = SS_WR_J;
                    end
                    SS_WR_J: begin
                        s_addr   = j;
                        s_wrdata = si;
                        s_wren   = 1'b1;
                        step_n   = SS_RD_K;
                    end
                    SS_RD_K: begin
                        s_addr = si + sj;
                        step_n = SS_WR_CT;
                    end
                    SS_WR_CT: begin
                        ct_addr   = k;
                        ct_wrdata = s_rddata ^ pt_byte;
                        ct_wren   = 1'b1;
                        step_n    = SS_RD_I;
                        if (k == len) begin
                            state_n = ST_DONE;
                        end else begin
                            k_n = k + ADDR_W'(1);
                        end
                    end
                    default: step_n = SS_RD_I;
                endcase
            end
            default: state_n = ST_IDLE;
        endcase
    end

`ifdef ARC4_ENC_CYCLE_COUNT_EN
    // Busy-cycle counter: cleared on accept, counts while not ready, holds otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            cycles <= '0;
        end else if (accept) begin
            cycles <= '0;
        end else if (!rdy) begin
            cycles <= cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_arc4_enc.sv
// Self-checking bench for arc4_enc: table of message runs checked against an
// ARC4 reference model through a ct-write scoreboard, plus reset and en/key corner cases.
module tb_arc4_enc;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [23:0] key;
    logic        rdy;
    logic [7:0]  pt_addr;
    logic [7:0]  pt_rddata;
    logic [7:0]  ct_addr;
    logic [7:0]  ct_wrdata;
    logic        ct_wren;
`ifdef ARC4_ENC_CYCLE_COUNT_EN
    logic [31:0] cycles;
`endif

    always #5 clk = ~clk;

    arc4_enc dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rdy       (rdy),
        .key       (key),
        .pt_addr   (pt_addr),
        .pt_rddata (pt_rddata),
        .ct_addr   (ct_addr),
        .ct_wrdata (ct_wrdata),
        .ct_wren   (ct_wren)
`ifdef ARC4_ENC_CYCLE_COUNT_EN
        ,
        .cycles    (cycles)
`endif
    );

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        logic [23:0] key;
        int          len;
        int          fill;
        int          pulse_at;
        logic [71:0] exp_head;
        bit          has_head;
    } vec_t;

    logic [7:0] pt_mem [256];
    logic [7:0] ct_mem [256];
    logic [7:0] ks     [256];
    wr_t        sb_q   [$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         wr_count = 0;
    int         max_pt   = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Plaintext RAM model: one-cycle read latency
    always @(posedge clk) begin
        pt_rddata <= pt_mem[pt_addr];
    end

    // Ciphertext RAM model and write scoreboard
    always @(negedge clk) begin : monitor
        wr_t e;
        if (!rst && ct_wren) begin
            ct_mem[ct_addr] = ct_wrdata;
            wr_count++;
            checkOutput("write_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                checkOutput("ct_addr", 32'(ct_addr), 32'(e.addr));
                checkOutput("ct_wrdata", 32'(ct_wrdata), 32'(e.data));
            end
        end
        if (!rst && !rdy && int'(pt_addr) > max_pt) begin
            max_pt = int'(pt_addr);
        end
    end

    // Reference ARC4 keystream for bytes 1..len
    task automatic computeKs(input logic [23:0] k, input int len);
        int s [256];
        int i;
        int j;
        int t;
        int kb;
        for (int n = 0; n < 256; n++) s[n] = n;
        j = 0;
        for (int n = 0; n < 256; n++) begin
            kb   = int'((k >> (8 * (2 - (n % 3)))) & 24'hFF);
            j    = (j + s[n] + kb) % 256;
            t    = s[n];
            s[n] = s[j];
            s[j] = t;
        end
        i = 0;
        j = 0;
        for (int n = 1; n <= len; n++) begin
            i     = (i + 1) % 256;
            j     = (j + s[i]) % 256;
            t     = s[i];
            s[i]  = s[j];
            s[j]  = t;
            ks[n] = 8'(s[(s[i] + s[j]) % 256]);
        end
    endtask

    task automatic startRun(input vec_t v);
        logic [71:0] txt;
        wr_t         e;
        txt = "Plaintext";
        pt_mem[0] = 8'(v.len);
        for (int n = 1; n <= v.len; n++) begin
            case (v.fill)
                0:       pt_mem[n] = txt[8*(9-n)+7 -: 8];
                1:       pt_mem[n] = 8'($urandom_range(0, 255));
                2:       pt_mem[n] = 8'(n);
                default: pt_mem[n] = 8'hFF;
            endcase
        end
        computeKs(v.key, v.len);
        sb_q.delete();
        e.addr = 8'd0;
        e.data = 8'(v.len);
        sb_q.push_back(e);
        for (int n = 1; n <= v.len; n++) begin
            e.addr = 8'(n);
            e.data = ks[n] ^ pt_mem[n];
            sb_q.push_back(e);
        end
        wr_count = 0;
        max_pt   = 0;
        @(posedge clk);
        #1;
        key = v.key;
        en  = 1'b1;
        @(posedge clk);
        #1;
        en  = 1'b0;
        key = ~v.key;
    endtask

    task automatic applyStimulus(input vec_t v);
        int busy;
        int limit;
        int errs;
        int wc;
        startRun(v);
        busy  = 0;
        limit = 1400 + 8 * v.len;
        while (!rdy && busy <= limit) begin
            if (v.pulse_at != 0 && busy == v.pulse_at) begin
                en  = 1'b1;
                key = 24'($urandom);
            end else begin
                en = 1'b0;
            end
            busy++;
            @(posedge clk);
            #1;
        end
        en = 1'b0;
        checkOutput("latency_bound", 32'(busy <= limit), 32'd1);
        checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);
        checkOutput("write_count", 32'(wr_count), 32'(v.len + 1));
        checkOutput("max_pt_addr", 32'(max_pt), 32'(v.len));
        checkOutput("ct_len_byte", 32'(ct_mem[0]), 32'(v.len));
        errs = 0;
        for (int n = 1; n <= v.len; n++) begin
            if ((ct_mem[n] ^ ks[n]) !== pt_mem[n]) errs++;
        end
        checkOutput("roundtrip_errs", 32'(errs), 32'd0);
        if (v.has_head) begin
            for (int n = 1; n <= 9; n++) begin
                checkOutput("known_ct", 32'(ct_mem[n]), 32'(v.exp_head[8*(9-n)+7 -: 8]));
            end
        end
`ifdef ARC4_ENC_CYCLE_COUNT_EN
        checkOutput("cycles", cycles, 32'(busy));
        if (v.len == 9) checkOutput("cycles_max", 32'(cycles <= 32'd1472), 32'd1);
`endif
        wc = wr_count;
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("rdy_hold", 32'(rdy), 32'd1);
        end
        checkOutput("no_extra_writes", 32'(wr_count), 32'(wc));
    endtask

    vec_t vecs [6];
    vec_t rv;

    initial begin
        int n;
        int wc;
        vecs[0] = '{24'h4B6579,   9, 0,   0, 72'hBBF316E8D940AF0AD3, 1'b1};
        vecs[1] = '{24'hA5A5A5,   0, 1,   0, 72'h0, 1'b0};
        vecs[2] = '{24'h1E4600, 200, 1,   0, 72'h0, 1'b0};
        vecs[3] = '{24'h000000, 255, 2,   0, 72'h0, 1'b0};
        vecs[4] = '{24'hFFFFFF,   1, 3,   0, 72'h0, 1'b0};
        vecs[5] = '{24'h123456,  16, 1, 500, 72'h0, 1'b0};
        for (int a = 0; a < 256; a++) begin
            pt_mem[a] = 8'h00;
            ct_mem[a] = 8'h00;
        end

        rst = 1'b1;
        en  = 1'b0;
        key = 24'h0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_rdy", 32'(rdy), 32'd1);
        checkOutput("reset_ct_wren", 32'(ct_wren), 32'd0);
        checkOutput("reset_pt_addr", 32'(pt_addr), 32'd0);
        checkOutput("reset_ct_addr", 32'(ct_addr), 32'd0);
        checkOutput("reset_ct_wrdata", 32'(ct_wrdata), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("idle_rdy", 32'(rdy), 32'd1);

        for (int v = 0; v < 6; v++) begin
            $display("[TB] run %0d: key=%h len=%0d", v, vecs[v].key, vecs[v].len);
            applyStimulus(vecs[v]);
        end

        $display("[TB] reset during PRGA");
        rv = '{24'h0BADF0, 20, 1, 0, 72'h0, 1'b0};
        startRun(rv);
        n = 0;
        while (wr_count < 5 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("reached_5_writes", 32'(wr_count), 32'd5);
        rst = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_rdy", 32'(rdy), 32'd1);
        checkOutput("rst_ct_wren", 32'(ct_wren), 32'd0);
        checkOutput("rst_ct_addr", 32'(ct_addr), 32'd0);
        checkOutput("rst_pt_addr", 32'(pt_addr), 32'd0);
        wc = wr_count;
        repeat (30) @(posedge clk);
        #1;
        checkOutput("no_write_after_rst", 32'(wr_count), 32'(wc));
        checkOutput("rdy_after_rst", 32'(rdy), 32'd1);
        applyStimulus(rv);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
